// File: rtl/mem_sys_pkg.sv
// Shared constants, state encoding and address-slice helpers for the memory-system
// responder and its backing store.
package mem_sys_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned LINES    = 8;
    localparam int unsigned MISS_LAT = 4;  // must be >= 1

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    localparam logic [DATA_W-1:0] MEM_INIT_XOR = 8'hA5;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:IDX_W];
    endfunction

    function automatic logic [IDX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/cache_responder_if.sv
// Processor-side request/response bundle between the request generator and the responder.
interface cache_responder_if
    import mem_sys_pkg::*;
();

    logic              req_valid;
    logic              req_ready;
    logic              RWB;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Data;
    logic              resp_valid;
    logic              Hit;
    logic [DATA_W-1:0] MemSysOut;
    logic [7:0]        hit_cnt;

    modport master (
        output req_valid, RWB, Address, Data,
        input  req_ready, resp_valid, Hit, MemSysOut, hit_cnt
    );

    modport slave (
        input  req_valid, RWB, Address, Data,
        output req_ready, resp_valid, Hit, MemSysOut, hit_cnt
    );

endinterface

// File: rtl/cache_responder_backing_mem.sv
// Single-ported 64x8 backing store: combinational read, synchronous write, and a
// synchronous reset that reloads the a ^ 0xA5 pattern.
module backing_mem
    import mem_sys_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= DATA_W'(a) ^ MEM_INIT_XOR;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cache_responder.sv
// Direct-mapped, write-through, no-write-allocate byte cache in front of a fixed-latency
// backing memory; hits answer on the accept edge, misses after MISS_LAT cycles.
module cache_responder
    import mem_sys_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    cache_responder_if.slave   bus
);

    localparam int unsigned CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    logic [0:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rwb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] line_q [LINES];

    logic              resp_valid_q;
    logic              hit_q;
    logic [DATA_W-1:0] out_q;
    logic [7:0]        hit_cnt_q;

    logic              accept;
    logic              lookup_hit;
    logic              done;
    logic [IDX_W-1:0]  in_idx;
    logic [IDX_W-1:0]  q_idx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign bus.req_ready = (state_q == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign in_idx        = get_index(bus.Address);
    assign q_idx         = get_index(addr_q);
    assign lookup_hit    = valid_q[in_idx] && (tag_q[in_idx] == get_tag(bus.Address));
    assign done          = (state_q == MEM_WAIT) && (cnt_q == '0);

    // Write hits go straight to memory on the accept edge; write misses on completion.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = data_q;
        if (accept && !bus.RWB && lookup_hit) begin
            mem_we    = 1'b1;
            mem_waddr = bus.Address;
            mem_wdata = bus.Data;
        end else if (done && !rwb_q) begin
            mem_we = 1'b1;
        end
    end

    backing_mem u_backing_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rwb_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            out_q        <= '0;
            hit_cnt_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            if (accept) begin
                rwb_q  <= bus.RWB;
                addr_q <= bus.Address;
                data_q <= bus.Data;
                if (lookup_hit) begin
                    resp_valid_q <= 1'b1;
                    hit_q        <= 1'b1;
                    out_q        <= bus.RWB ? line_q[in_idx] : bus.Data;
                    if (hit_cnt_q != 8'hFF) hit_cnt_q <= hit_cnt_q + 8'd1;
                end else begin
                    state_q <= MEM_WAIT;
                    cnt_q   <= CNT_W'(MISS_LAT - 1);
                end
            end else if (state_q == MEM_WAIT) begin
                if (cnt_q == '0) begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b1;
                    out_q        <= rwb_q ? mem_rdata : data_q;
                    if (rwb_q) valid_q[q_idx] <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    // Tag/data need no reset: valid_q gates every use of them.
    always_ff @(posedge clk) begin
        if (accept && !bus.RWB && lookup_hit) begin
            line_q[in_idx] <= bus.Data;
        end else if (done && rwb_q) begin
            tag_q[q_idx]  <= get_tag(addr_q);
            line_q[q_idx] <= mem_rdata;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.Hit        = hit_q;
    assign bus.MemSysOut  = out_q;
    assign bus.hit_cnt    = hit_cnt_q;

endmodule
